// File: rtl/led_panel_receiver.sv
// led_panel_receiver: samples the serial LED panel bus and re-emits each latched scan line as a column write stream
module led_panel_receiver #(
  parameter int DISPLAY_WIDTH   = 416,
  parameter int COL_WIDTH       = 9,
  parameter int DISP_ADDR_WIDTH = 3,
  parameter int PLANES          = 8,
  parameter int PLANE_WIDTH     = 3
) (
  input  logic                       clk_48mhz,
  input  logic                       reset,
  input  logic                       panel_clk,
  input  logic                       panel_data,
  input  logic                       panel_latch,
  input  logic [DISP_ADDR_WIDTH-1:0] panel_addr,
  output logic                       wr_en,
  output logic [DISP_ADDR_WIDTH-1:0] wr_row,
  output logic [COL_WIDTH-1:0]       wr_col,
  output logic [PLANE_WIDTH-1:0]     wr_plane,
  output logic                       wr_bit,
  output logic                       frame_start,
  output logic                       line_error,
  output logic                       overrun
);
  localparam int CW = COL_WIDTH + 1;
  localparam logic [CW-1:0] LEN = CW'(DISPLAY_WIDTH);
  localparam logic [CW-1:0] SAT = CW'(DISPLAY_WIDTH + 1);
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(DISPLAY_WIDTH - 1);
  localparam logic [PLANE_WIDTH-1:0] LAST_PLANE = PLANE_WIDTH'(PLANES - 1);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_next;
  logic [1:0] clk_sync, data_sync, latch_sync;
  logic [1:0][DISP_ADDR_WIDTH-1:0] addr_sync;
  logic clk_prev, latch_prev, clk_rise, latch_rise, latch_lvl, data_bit;
  logic [DISP_ADDR_WIDTH-1:0] addr_lat, row;
  logic [1:0][DISPLAY_WIDTH-1:0] bufs;
  logic sel, first;
  logic [CW-1:0] bit_count;
  logic [PLANE_WIDTH-1:0] plane, next_plane;
  logic [COL_WIDTH-1:0] col, col_next;
  logic accept, drop;
  assign accept = latch_rise && state == IDLE;
  assign drop = latch_rise && state == EMIT;
  // two-flop synchronizers, then a registered edge-detect stage aligned with data, level and address
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      clk_sync <= '0;
      data_sync <= '0;
      latch_sync <= '0;
      addr_sync <= '0;
      clk_prev <= 1'b0;
      latch_prev <= 1'b0;
      clk_rise <= 1'b0;
      latch_rise <= 1'b0;
      latch_lvl <= 1'b0;
      data_bit <= 1'b0;
      addr_lat <= '0;
    end else begin
      clk_sync <= {clk_sync[0], panel_clk};
      data_sync <= {data_sync[0], panel_data};
      latch_sync <= {latch_sync[0], panel_latch};
      addr_sync <= {addr_sync[0], panel_addr};
      clk_prev <= clk_sync[1];
      latch_prev <= latch_sync[1];
      clk_rise <= clk_sync[1] & ~clk_prev;
      latch_rise <= latch_sync[1] & ~latch_prev;
      latch_lvl <= latch_sync[1];
      data_bit <= data_sync[1];
      addr_lat <= addr_sync[1];
    end
  end
  // plane advances on repeated latches of the same row and wraps after the last plane
  always_comb begin
    next_plane = (first || addr_lat != row || plane == LAST_PLANE) ? '0 : plane + PLANE_WIDTH'(1);
  end
  // bit capture into the ping-pong buffer, latch bookkeeping and status pulses
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      bufs <= '0;
      sel <= 1'b0;
      first <= 1'b1;
      bit_count <= '0;
      row <= '0;
      plane <= '0;
      line_error <= 1'b0;
      frame_start <= 1'b0;
      overrun <= 1'b0;
    end else begin
      line_error <= accept && bit_count != LEN;
      frame_start <= accept && addr_lat == '0 && next_plane == '0;
      overrun <= drop;
      if (accept) begin
        sel <= ~sel;
        bufs[~sel] <= '0;
        row <= addr_lat;
        plane <= next_plane;
        first <= 1'b0;
        bit_count <= '0;
      end else if (drop) begin
        bufs[sel] <= '0;
        bit_count <= '0;
      end else if (clk_rise && !latch_lvl && bit_count != SAT) begin
        if (bit_count < LEN) bufs[sel][bit_count[COL_WIDTH-1:0]] <= data_bit;
        bit_count <= bit_count + CW'(1);
      end
    end
  end
  // emitter state and column counter
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state <= IDLE;
      col <= '0;
    end else begin
      state <= state_next;
      col <= col_next;
    end
  end
  // start on an accepted latch, stop after the last column
  always_comb begin
    state_next = accept ? EMIT : (state == EMIT && col == LAST_COL) ? IDLE : state;
    col_next = (state == EMIT) ? col + COL_WIDTH'(1) : '0;
  end
  // registered write port reading the emit half of the ping-pong buffer
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_en <= 1'b0;
      wr_col <= '0;
      wr_bit <= 1'b0;
      wr_row <= '0;
      wr_plane <= '0;
    end else begin
      wr_en <= state == EMIT;
      wr_col <= col;
      wr_bit <= state == EMIT && bufs[~sel][col];
      wr_row <= row;
      wr_plane <= plane;
    end
  end
endmodule

// File: tb/tb_led_panel_receiver.sv
// tb_led_panel_receiver: directed line-by-line checks of the panel receiver write stream
module tb_led_panel_receiver;
  logic clk_48mhz = 1'b0;
  logic reset = 1'b1;
  logic panel_clk = 1'b0, panel_data = 1'b0, panel_latch = 1'b0;
  logic [2:0] panel_addr = '0;
  logic wr_en, wr_bit, frame_start, line_error, overrun;
  logic [2:0] wr_row, wr_plane;
  logic [8:0] wr_col;
  int checks = 0, errors = 0;
  int n_wr, col_bad, const_bad, n_fs, n_le, n_ov;
  int row_seen, plane_seen;
  logic line_bits [416];

  led_panel_receiver dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .panel_clk(panel_clk), .panel_data(panel_data),
    .panel_latch(panel_latch), .panel_addr(panel_addr), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_plane(wr_plane), .wr_bit(wr_bit), .frame_start(frame_start),
    .line_error(line_error), .overrun(overrun)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  always @(negedge clk_48mhz) begin
    if (wr_en) begin
      if (int'(wr_col) != n_wr % 416) col_bad++;
      if (n_wr > 0 && (int'(wr_row) != row_seen || int'(wr_plane) != plane_seen)) const_bad++;
      row_seen = int'(wr_row);
      plane_seen = int'(wr_plane);
      line_bits[wr_col] = wr_bit;
      n_wr++;
    end
    if (frame_start) n_fs++;
    if (line_error) n_le++;
    if (overrun) n_ov++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_48mhz);
    #1;
  endtask

  function automatic logic pat(input int mode, input int i);
    return mode == 0 ? logic'(i % 2 == 0) : logic'((i * 7 + mode) % 5 < 2);
  endfunction

  task automatic clear_mon();
    n_wr = 0; col_bad = 0; const_bad = 0; n_fs = 0; n_le = 0; n_ov = 0;
    row_seen = -1; plane_seen = -1;
    for (int i = 0; i < 416; i++) line_bits[i] = 1'bx;
  endtask

  task automatic send_bits(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      panel_clk = 1'b0;
      panel_data = pat(mode, i);
      tick();
      panel_clk = 1'b1;
      tick();
    end
  endtask

  // driver pattern: clock rises together with the latch and is not a data bit
  task automatic do_latch(input int addr, output int lat);
    panel_addr = 3'(addr);
    panel_clk = 1'b0;
    tick();
    panel_latch = 1'b1;
    panel_clk = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) panel_clk = 1'b0;
      if (lat == 2) panel_latch = 1'b0;
    end while (lat < 3 || (!wr_en && lat < 20));
  endtask

  task automatic run_line(input int nbits, input int mode, input int addr, input int exp_plane,
                          input int exp_le, input int exp_fs);
    int lat, bad;
    clear_mon();
    send_bits(nbits, mode);
    do_latch(addr, lat);
    repeat (430) tick();
    bad = 0;
    for (int i = 0; i < 416; i++)
      if (line_bits[i] !== ((i < nbits) ? pat(mode, i) : 1'b0)) bad++;
    check("latency", lat, 5);
    check("writes", n_wr, 416);
    check("col_order", col_bad, 0);
    check("row_plane_const", const_bad, 0);
    check("bits", bad, 0);
    check("row", row_seen, addr);
    check("plane", plane_seen, exp_plane);
    check("line_error", n_le, exp_le);
    check("frame_start", n_fs, exp_fs);
    check("overrun", n_ov, 0);
  endtask

  initial begin
    int lat, lat2, guard;
    clear_mon();
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_col", int'(wr_col), 0);
    check("rst_pulses", int'({frame_start, line_error, overrun}), 0);
    run_line(416, 0, 3, 0, 0, 0);
    for (int p = 0; p < 8; p++) run_line(416, 1, 5, p, 0, 0);
    run_line(416, 2, 6, 0, 0, 0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int p = 0; p < 9; p++) run_line(416, 3, 0, p % 8, 0, (p % 8 == 0) ? 1 : 0);
    run_line(415, 0, 7, 0, 1, 0);
    run_line(417, 4, 7, 1, 1, 0);
    clear_mon();
    send_bits(416, 0);
    do_latch(2, lat);
    repeat (95) tick();
    do_latch(4, lat2);
    repeat (430) tick();
    check("ovr_latency", lat, 5);
    check("ovr_pulse", n_ov, 1);
    check("ovr_writes", n_wr, 416);
    check("ovr_row", row_seen, 2);
    check("ovr_line_error", n_le, 0);
    clear_mon();
    send_bits(416, 1);
    do_latch(1, lat);
    guard = 0;
    while (!(wr_en && wr_col == 9'd200) && guard < 1000) begin
      tick();
      guard++;
    end
    check("col200_reached", int'(guard < 1000), 1);
    reset = 1'b1;
    tick();
    check("rst_mid_wr_en", int'(wr_en), 0);
    check("rst_mid_outs", int'({wr_row, wr_col, wr_plane, wr_bit}), 0);
    reset = 1'b0;
    repeat (450) tick();
    check("rst_mid_writes", n_wr, 201);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_panel_receiver.md
Name: led_panel_receiver

Overview:
- Receive-side counterpart of the team's LED matrix shift-register driver, i.e. a panel emulator/sniffer.
- Oversamples the serial panel bus (clock, data, latch, row address) in the 48 MHz domain, which is 2x the 24 MHz driver clock.
- Reassembles each latched scan line and emits it as a column-ordered write stream tagged with row and bit-plane.
- Used for loopback verification of the HDMI→framebuffer→panel path and for capturing panel content back into a framebuffer.

Parameters:
- DISPLAY_WIDTH, 416, data bits shifted per scan line (columns).
- COL_WIDTH, 9, width of column index; must satisfy 2^COL_WIDTH ≥ DISPLAY_WIDTH.
- DISP_ADDR_WIDTH, 3, panel row-address width.
- PLANES, 8, binary-coded-modulation bit planes per row.
- PLANE_WIDTH, 3, width of plane index.

Ports:
- clk_48mhz  in  1  system clock
- reset  in  1  synchronous, active-high
- panel_clk  in  1  panel shift clock (async)
- panel_data  in  1  panel serial data (async)
- panel_latch  in  1  panel latch (async)
- panel_addr  in  DISP_ADDR_WIDTH  panel row address (async)
- wr_en  out  1  write strobe, one column per cycle
- wr_row  out  DISP_ADDR_WIDTH  row of current write
- wr_col  out  COL_WIDTH  column of current write
- wr_plane  out  PLANE_WIDTH  bit plane of current write
- wr_bit  out  1  pixel bit value
- frame_start  out  1  1-cycle pulse: latch with row 0, plane 0
- line_error  out  1  1-cycle pulse: latched bit count ≠ DISPLAY_WIDTH
- overrun  out  1  1-cycle pulse: latch arrived while previous line still emitting; line dropped

Behaviour:
- Input conditioning: all panel inputs pass through 2-FF synchronizers. Edges are detected on a third registered stage.
  - clk_rise = sync & ~prev; latch_rise likewise.
- Bit capture:
  - On clk_rise with synchronized latch low, store panel_data into capture buffer [bit_count] and increment bit_count.
  - clk_rise coinciding with latch high, or with latch_rise, is NOT a data bit (driver raises clock together with latch).
  - Bits beyond DISPLAY_WIDTH-1 are discarded; bit_count saturates at DISPLAY_WIDTH+1.
- Latch handling (on latch_rise):
  - Sample panel_addr → row.
  - plane = 0 if row ≠ prev_row, or if prev plane = PLANES-1, or if this is the first latch since reset; otherwise plane = prev_plane+1.
  - line_error pulses the next cycle if bit_count ≠ DISPLAY_WIDTH; columns not received emit wr_bit=0.
  - Swap capture/emit buffers (ping-pong, 2×DISPLAY_WIDTH bits); clear the new capture buffer and set bit_count=0.
  - frame_start pulses the next cycle if row=0 and plane=0.
- Emitter FSM:
  - IDLE→EMIT on the cycle after latch_rise.
  - EMIT drives wr_en=1 for exactly DISPLAY_WIDTH consecutive cycles, wr_col 0..DISPLAY_WIDTH-1 ascending, with wr_row/wr_plane constant.
  - EMIT→IDLE after column DISPLAY_WIDTH-1.
  - latch_rise during EMIT: the new line is dropped (no buffer swap, plane/row tracking not updated), overrun pulses, and capture restarts with bit_count=0.
- Latency: first wr_en occurs 5 cycles after the panel_latch rising edge at the pin (2 sync + 1 edge + 1 swap + 1 output register).
- Reset:
  - All outputs 0; FSM IDLE; bit_count 0; buffers cleared; first-latch flag set.
  - Reset mid-EMIT aborts immediately; no further wr_en.
- panel enable input is not required; brightness is recovered via plane index only.

Test Plan:
- 416 bits of alternating 1,0 at 24 MHz then latch, addr=3 → 416 wr_en cycles; wr_col 0..415; wr_bit alternates starting 1; wr_row=3; wr_plane=0; no line_error.
- 8 lines with addr=5, then 1 line with addr=6 → wr_plane 0..7 for row 5, then plane 0 for row 6; frame_start never pulses.
- Addr=0 first latch after reset → frame_start one pulse; 9th latch at addr=0 after 8 planes → frame_start pulses again.
- 415 bits then latch → line_error pulse; column 415 emitted with wr_bit=0. 417 bits → line_error; 417th bit absent from output.
- Clock rise coincident with latch (driver pattern) → not counted; line of exactly 416 data rises plus a coincident rise → no line_error.
- Second latch 100 cycles after first → overrun pulse; only first line's 416 writes appear. Reset asserted at column 200 → wr_en low next cycle, outputs 0.
